memory_access_controller: RTL
=============================

Name: memory_access_controller

Overview:
Sequences every access to the 8-word memory array (3-bit address into the 3-to-8 word-select decoder, plus per-word storage cells). It arbitrates between two requesters using round-robin arbitration. For each granted access it drives address, select and write-enable in a fixed setup/strobe/hold sequence, so the decoder output is never glitched while select is high. It captures read data and returns a single-cycle acknowledge to the winning requester.

Parameters:
WIDTH, 4, data word width in bits
STROBE_CYCLES, 2, cycles select stays high per access; legal range 1..15

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req0  input  1  requester 0 access request, level
we0  input  1  requester 0: 1 = write, 0 = read
adr0  input  3  requester 0 word address
wdata0  input  WIDTH  requester 0 write data
ack0  output  1  requester 0 completion pulse
req1  input  1  requester 1 access request, level
we1  input  1  requester 1: 1 = write, 0 = read
adr1  input  3  requester 1 word address
wdata1  input  WIDTH  requester 1 write data
ack1  output  1  requester 1 completion pulse
rdata  output  WIDTH  read data of the last completed read
mem_adr  output  3  to decoder address inputs (bit 2 to adr2, bit 1 to adr1, bit 0 to adr0)
mem_select  output  1  to decoder select
mem_we  output  1  write enable to storage cells
mem_wdata  output  WIDTH  write data to storage cells
mem_rdata  input  WIDTH  data read from the selected word
busy  output  1  high in every state except IDLE
grant_id  output  1  requester owning the current or most recent access

Behaviour:
- Reset is asynchronous and active-high: clk and reset, one clock domain. All outputs are registered.
- Reset values: ack0=0, ack1=0, rdata=0, mem_adr=0, mem_select=0, mem_we=0, mem_wdata=0, busy=0, grant_id=0. FSM goes to IDLE. Round-robin pointer last=1, so requester 0 wins the first tie.
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE: samples req0 and req1 on each edge.
  - Neither high: stay in IDLE.
  - Exactly one high: grant it.
  - Both high: grant the requester that is not last.
  - On the grant edge: latch we, adr and wdata of the winner into mem_we_q, mem_adr and mem_wdata. Set grant_id and last to the winner. Go to SETUP.
  - Operand changes after the grant edge are ignored.
- SETUP: lasts 1 cycle. mem_adr and mem_wdata are stable, mem_select=0, mem_we=0. Next state is STROBE and the strobe counter loads 1.
- STROBE: lasts STROBE_CYCLES cycles.
  - mem_select=1.
  - mem_we equals the latched we.
  - mem_adr and mem_wdata stay constant.
  - On the edge that ends the last STROBE cycle: if the access is a read, rdata <= mem_rdata. Then go to HOLD.
- HOLD: lasts 1 cycle. mem_select=0, mem_we=0, address still held. Next state is DONE.
- DONE: lasts 1 cycle. ack of the granted requester is 1 and the other ack is 0. Next state is IDLE.
- Latency: ack is high during the cycle after edge number STROBE_CYCLES+2 following the grant edge. With the default setting that is 4 edges. Total occupancy is STROBE_CYCLES+3 cycles, then at least one IDLE cycle before the next grant.
- Handshake: a requester holds req until it sees ack and must drop req on the edge where ack is sampled high. If req is still high in the following IDLE cycle, it is treated as a new request.
- mem_adr and mem_wdata hold their last value in IDLE. mem_select and mem_we are 0 outside STROBE.
- rdata holds its value across writes and idle time. It changes only at the read-capture edge.
- Reset asserted mid-access:
  - All outputs go to their reset values immediately and the access is abandoned with no ack.
  - A write interrupted during STROBE may leave that word undefined.
  - After reset is released, the FSM restarts from IDLE.
- mem_select and mem_we never rise in the same cycle that mem_adr changes.

Test Plan:
- Reset: assert reset for 3 cycles with random inputs, then release -> all outputs 0 and busy=0. Assert reset mid-STROBE -> mem_select drops without waiting for a clock edge and ack0/ack1 stay 0.
- Single write then read (STROBE_CYCLES=2): req0, we0=1, adr0=5, wdata0=4'hA.
  - mem_select is high exactly 2 cycles with mem_adr=5 and mem_we=1.
  - ack0 pulses once, on the 4th edge after the grant edge.
  - Then req0 read of adr0=5 -> rdata=4'hA on ack0.
- Simultaneous requests: req0 and req1 both high from reset (req0 adr=1, req1 adr=2).
  - Grant order is 0, 1, 0, 1 while both are held high (each re-raising after its ack).
  - grant_id matches the grant order and each ack is exclusive.
- Full address sweep: write value i to adr i for i = 0..7, then read all 8.
  - Each read returns i, including adr 0 and adr 7.
  - mem_adr is stable whenever mem_select=1.
- Operand change after grant: requester 1 changes adr1 from 3 to 6 during STROBE -> the access still uses address 3 and the next access uses the new value.
- Idle behaviour: no requests for 20 cycles -> busy=0, mem_select=0, mem_we=0, and rdata keeps the last read value.

Source files
------------

// File: rtl/memory_access_controller.sv
// Round-robin two-port sequencer for the 8-word array: setup / strobe / hold / done
// per access, so the decoder address is always settled before select rises.
module memory_access_controller #(
  parameter int WIDTH         = 4,
  parameter int STROBE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             we0,
  input  logic [2:0]       adr0,
  input  logic [WIDTH-1:0] wdata0,
  output logic             ack0,
  input  logic             req1,
  input  logic             we1,
  input  logic [2:0]       adr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             ack1,
  output logic [WIDTH-1:0] rdata,
  output logic [2:0]       mem_adr,
  output logic             mem_select,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy,
  output logic             grant_id
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] STROBE = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [3:0] CNT_LAST = 4'(STROBE_CYCLES);

  typedef struct packed {
    logic             we;
    logic [2:0]       adr;
    logic [WIDTH-1:0] wdata;
  } acc_t;

  logic [2:0] state;
  logic [3:0] cnt;
  logic       mem_we_q;
  logic       last;
  logic       win_id;
  acc_t       r0, r1, win;

  assign r0 = {we0, adr0, wdata0};
  assign r1 = {we1, adr1, wdata1};

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    win_id = (req0 & req1) ? ~last : req1;
    win    = win_id ? r1 : r0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      mem_we_q   <= 1'b0;
      last       <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata      <= '0;
      mem_adr    <= 3'd0;
      mem_select <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      grant_id   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req0 | req1) begin
          mem_we_q  <= win.we;
          mem_adr   <= win.adr;
          mem_wdata <= win.wdata;
          grant_id  <= win_id;
          last      <= win_id;
          busy      <= 1'b1;
          state     <= SETUP;
        end
        SETUP: begin
          cnt        <= 4'd1;
          mem_select <= 1'b1;
          mem_we     <= mem_we_q;
          state      <= STROBE;
        end
        STROBE: begin
          if (cnt == CNT_LAST) begin
            if (!mem_we_q) rdata <= mem_rdata;
            mem_select <= 1'b0;
            mem_we     <= 1'b0;
            state      <= HOLD;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HOLD: begin
          ack0  <= ~grant_id;
          ack1  <= grant_id;
          state <= DONE;
        end
        DONE: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
